// File: rtl/hiscore_ioctl_host.sv
// Host-side byte buffer that streams to (download) or captures from (upload)
// a core over the ioctl bus, with programmable setup/gap/settle/hold timing.
module hiscore_ioctl_host #(
  parameter int BUF_AWIDTH   = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int WR_GAP       = 3,
  parameter int RD_SETTLE    = 4,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_download,
  input  logic                  start_upload,
  input  logic [7:0]            index,
  input  logic [BUF_AWIDTH:0]   len,
  input  logic                  buf_wr,
  input  logic [BUF_AWIDTH-1:0] buf_addr,
  input  logic [7:0]            buf_din,
  output logic [7:0]            buf_dout,
  output logic                  ioctl_download,
  output logic                  ioctl_upload,
  output logic                  ioctl_wr,
  output logic [24:0]           ioctl_addr,
  output logic [7:0]            ioctl_dout,
  input  logic [7:0]            ioctl_din,
  output logic [7:0]            ioctl_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, DL_WR, DL_GAP, UL_SETTLE, UL_CAP, HOLD, DONE
  } state_t;

  localparam logic [BUF_AWIDTH:0] MAX_LEN = {1'b1, {BUF_AWIDTH{1'b0}}};

  state_t                state;
  logic [15:0]           cnt;
  logic [BUF_AWIDTH:0]   len_q;
  logic [BUF_AWIDTH-1:0] addr;
  logic [7:0]            mem [0:(2**BUF_AWIDTH)-1];

  logic                  last;
  logic                  load_dout;
  logic [BUF_AWIDTH-1:0] rd_addr;
  logic                  we;
  logic [BUF_AWIDTH-1:0] wa;
  logic [7:0]            wd;

  assign ioctl_addr = {{(25-BUF_AWIDTH){1'b0}}, addr};
  assign last = ({1'b0, addr} == len_q - 1'b1);

  // Fetch the next byte on the same edge that raises ioctl_wr,
  // so dout and addr change together and then stay put.
  always_comb begin
    load_dout = 1'b0;
    rd_addr   = addr + 1'b1;
    if (state == SETUP && cnt == 16'd0 &&
        len_q != '0 && ioctl_download) begin
      load_dout = 1'b1;
      rd_addr   = '0;
    end else if (state == DL_GAP && cnt == 16'd0 && !last) begin
      load_dout = 1'b1;
    end
  end

  assign we = (!busy && buf_wr) || (state == UL_CAP);
  assign wa = busy ? addr : buf_addr;
  assign wd = busy ? ioctl_din : buf_din;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    buf_dout <= mem[buf_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) ioctl_dout <= 8'h00;
    else if (load_dout) ioctl_dout <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      len_q          <= '0;
      addr           <= '0;
      ioctl_download <= 1'b0;
      ioctl_upload   <= 1'b0;
      ioctl_wr       <= 1'b0;
      ioctl_index    <= 8'h00;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done     <= 1'b0;
      ioctl_wr <= 1'b0;
      unique case (state)
        IDLE: if (start_download || start_upload) begin
          state          <= SETUP;
          busy           <= 1'b1;
          ioctl_download <= start_download;
          ioctl_upload   <= !start_download;
          ioctl_index    <= index;
          len_q          <= (len > MAX_LEN) ? MAX_LEN : len;
          addr           <= '0;
          cnt            <= 16'(SETUP_CYCLES - 1);
        end
        SETUP: if (cnt == 16'd0) begin
          if (len_q == '0) begin
            state <= HOLD;
            cnt   <= 16'(HOLD_CYCLES - 1);
          end else if (ioctl_download) begin
            state    <= DL_WR;
            ioctl_wr <= 1'b1;
          end else begin
            state <= UL_SETTLE;
            cnt   <= 16'(RD_SETTLE - 1);
          end
        end else cnt <= cnt - 1'b1;
        DL_WR: begin
          state <= DL_GAP;
          cnt   <= 16'(WR_GAP - 1);
        end
        DL_GAP: if (cnt == 16'd0) begin
          if (last) begin
            state <= HOLD;
            cnt   <= 16'(HOLD_CYCLES - 1);
          end else begin
            state    <= DL_WR;
            addr     <= addr + 1'b1;
            ioctl_wr <= 1'b1;
          end
        end else cnt <= cnt - 1'b1;
        UL_SETTLE: if (cnt == 16'd0) state <= UL_CAP;
          else cnt <= cnt - 1'b1;
        UL_CAP: if (last) begin
          state <= HOLD;
          cnt   <= 16'(HOLD_CYCLES - 1);
        end else begin
          state <= UL_SETTLE;
          addr  <= addr + 1'b1;
          cnt   <= 16'(RD_SETTLE - 1);
        end
        HOLD: if (cnt == 16'd0) begin
          state <= DONE;
          done  <= 1'b1;
        end else cnt <= cnt - 1'b1;
        DONE: begin
          state          <= IDLE;
          busy           <= 1'b0;
          ioctl_download <= 1'b0;
          ioctl_upload   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hiscore_ioctl_host.sv
// Directed bench for hiscore_ioctl_host: download, upload, len=0,
// start arbitration, mid-transfer reset and full-buffer/clamped lengths.
module tb_hiscore_ioctl_host;

  localparam int WR_GAP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_download = 1'b0;
  logic        start_upload = 1'b0;
  logic [7:0]  index = 8'h00;
  logic [8:0]  len = 9'd0;
  logic        buf_wr = 1'b0;
  logic [7:0]  buf_addr = 8'h00;
  logic [7:0]  buf_din = 8'h00;
  logic [7:0]  buf_dout;
  logic        ioctl_download, ioctl_upload, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_din, ioctl_index;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_buf [0:255];
  logic       mon_clr = 1'b0;
  int cyc = 0, last_wr = 0, wr_cnt = 0, done_cnt = 0;
  int dl_cyc = 0, ul_cyc = 0, mon_bad = 0;
  logic [24:0] last_addr = '0;

  hiscore_ioctl_host dut (
    .clk(clk), .reset(reset),
    .start_download(start_download), .start_upload(start_upload),
    .index(index), .len(len),
    .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_din(buf_din),
    .buf_dout(buf_dout),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_index(ioctl_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign ioctl_din = ioctl_upload ? ioctl_addr[7:0] + 8'hA0 : 8'h55;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      wr_cnt = 0; done_cnt = 0; dl_cyc = 0; ul_cyc = 0;
      mon_bad = 0; last_addr = '0;
    end else begin
      if (ioctl_download) dl_cyc++;
      if (ioctl_upload) ul_cyc++;
      if (done) done_cnt++;
      if (ioctl_download && ioctl_upload) mon_bad++;
      if (ioctl_wr) begin
        if (!ioctl_download || ioctl_upload) mon_bad++;
        if (ioctl_addr !== 25'(wr_cnt)) mon_bad++;
        if (ioctl_dout !== exp_buf[ioctl_addr[7:0]]) mon_bad++;
        if (wr_cnt > 0 && cyc - last_wr != 1 + WR_GAP) mon_bad++;
        last_wr = cyc;
        last_addr = ioctl_addr;
        wr_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    buf_addr = a; buf_din = d; buf_wr = 1'b1;
    tick();
    buf_wr = 1'b0;
    exp_buf[a] = d;
  endtask

  task automatic start(input logic dl, input logic ul,
                       input logic [7:0] idx, input logic [8:0] l);
    start_download = dl; start_upload = ul; index = idx; len = l;
    tick();
    start_download = 1'b0; start_upload = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s_timeout busy=%0b want=0", name, busy);
    end
  endtask

  task automatic load_pattern();
    logic [7:0] p [0:7];
    p = '{8'h00, 8'h00, 8'h43, 8'h0B, 8'h0F, 8'h10, 8'h01, 8'h00};
    for (int i = 0; i < 8; i++) host_write(8'(i), p[i]);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total += 8;
    if (ioctl_download !== 1'b0) begin bad++; $display("FAIL rst_dl got=%0b want=0", ioctl_download); end
    if (ioctl_upload !== 1'b0) begin bad++; $display("FAIL rst_ul got=%0b want=0", ioctl_upload); end
    if (ioctl_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%0b want=0", ioctl_wr); end
    if (ioctl_addr !== 25'd0) begin bad++; $display("FAIL rst_addr got=%0h want=0", ioctl_addr); end
    if (ioctl_dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%0h want=0", ioctl_dout); end
    if (ioctl_index !== 8'h00) begin bad++; $display("FAIL rst_index got=%0h want=0", ioctl_index); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_download();
    load_pattern();
    clr_mon();
    start(1'b1, 1'b0, 8'd3, 9'd8);
    total += 5;
    if (busy !== 1'b1) begin bad++; $display("FAIL dl_busy got=%0b want=1", busy); end
    if (ioctl_download !== 1'b1) begin bad++; $display("FAIL dl_flag got=%0b want=1", ioctl_download); end
    if (ioctl_upload !== 1'b0) begin bad++; $display("FAIL dl_ulflag got=%0b want=0", ioctl_upload); end
    if (ioctl_index !== 8'd3) begin bad++; $display("FAIL dl_index got=%0h want=3", ioctl_index); end
    if (ioctl_addr !== 25'd0) begin bad++; $display("FAIL dl_addr0 got=%0h want=0", ioctl_addr); end
    wait_idle("dl");
    total += 5;
    if (wr_cnt != 8) begin bad++; $display("FAIL dl_pulses got=%0d want=8", wr_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL dl_done got=%0d want=1", done_cnt); end
    if (mon_bad != 0) begin bad++; $display("FAIL dl_stream errors=%0d want=0", mon_bad); end
    if (dl_cyc != 37) begin bad++; $display("FAIL dl_cycles got=%0d want=37", dl_cyc); end
    if (last_addr !== 25'd7) begin bad++; $display("FAIL dl_last got=%0h want=7", last_addr); end
  endtask

  task automatic test_upload();
    logic [7:0] want;
    clr_mon();
    start(1'b0, 1'b1, 8'd4, 9'd4);
    total += 3;
    if (ioctl_upload !== 1'b1) begin bad++; $display("FAIL ul_flag got=%0b want=1", ioctl_upload); end
    if (ioctl_download !== 1'b0) begin bad++; $display("FAIL ul_dlflag got=%0b want=0", ioctl_download); end
    if (ioctl_index !== 8'd4) begin bad++; $display("FAIL ul_index got=%0h want=4", ioctl_index); end
    tick();
    host_write(8'd5, 8'hEE);
    exp_buf[5] = 8'h10;
    wait_idle("ul");
    for (int i = 0; i < 4; i++) exp_buf[i] = 8'hA0 + 8'(i);
    total += 4;
    if (wr_cnt != 0) begin bad++; $display("FAIL ul_wr got=%0d want=0", wr_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL ul_done got=%0d want=1", done_cnt); end
    if (ul_cyc != 25) begin bad++; $display("FAIL ul_cycles got=%0d want=25", ul_cyc); end
    if (mon_bad != 0) begin bad++; $display("FAIL ul_flags errors=%0d want=0", mon_bad); end
    for (int i = 0; i < 6; i++) begin
      buf_addr = 8'(i);
      tick();
      want = exp_buf[i];
      total++;
      if (buf_dout !== want) begin
        bad++; $display("FAIL ul_buf[%0d] got=%0h want=%0h", i, buf_dout, want);
      end
    end
  endtask

  task automatic test_len0();
    clr_mon();
    start(1'b1, 1'b0, 8'd1, 9'd0);
    wait_idle("len0");
    total += 3;
    if (wr_cnt != 0) begin bad++; $display("FAIL len0_wr got=%0d want=0", wr_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL len0_done got=%0d want=1", done_cnt); end
    if (dl_cyc != 5) begin bad++; $display("FAIL len0_cycles got=%0d want=5", dl_cyc); end
  endtask

  task automatic test_both_starts();
    clr_mon();
    start(1'b1, 1'b1, 8'd7, 9'd2);
    total += 2;
    if (ioctl_download !== 1'b1) begin bad++; $display("FAIL both_dl got=%0b want=1", ioctl_download); end
    if (ioctl_upload !== 1'b0) begin bad++; $display("FAIL both_ul got=%0b want=0", ioctl_upload); end
    repeat (4) tick();
    start(1'b0, 1'b1, 8'd9, 9'd3);
    wait_idle("both");
    repeat (10) tick();
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL both_extra busy=%0b want=0", busy); end
    if (ul_cyc != 0) begin bad++; $display("FAIL both_ulcyc got=%0d want=0", ul_cyc); end
    if (done_cnt != 1) begin bad++; $display("FAIL both_done got=%0d want=1", done_cnt); end
    if (wr_cnt != 2) begin bad++; $display("FAIL both_wr got=%0d want=2", wr_cnt); end
    if (mon_bad != 0) begin bad++; $display("FAIL both_stream errors=%0d want=0", mon_bad); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load_pattern();
    clr_mon();
    start(1'b1, 1'b0, 8'd3, 9'd8);
    while (wr_cnt < 3 && n < 200) begin tick(); n++; end
    total++;
    if (wr_cnt != 3) begin bad++; $display("FAIL mid_reach got=%0d want=3", wr_cnt); end
    reset = 1'b1;
    tick();
    total += 6;
    if (ioctl_download !== 1'b0) begin bad++; $display("FAIL mid_dl got=%0b want=0", ioctl_download); end
    if (ioctl_wr !== 1'b0) begin bad++; $display("FAIL mid_wr got=%0b want=0", ioctl_wr); end
    if (ioctl_addr !== 25'd0) begin bad++; $display("FAIL mid_addr got=%0h want=0", ioctl_addr); end
    if (ioctl_dout !== 8'h00) begin bad++; $display("FAIL mid_dout got=%0h want=0", ioctl_dout); end
    if (ioctl_index !== 8'h00) begin bad++; $display("FAIL mid_index got=%0h want=0", ioctl_index); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
    reset = 1'b0;
    repeat (20) tick();
    total++;
    if (done_cnt != 0) begin bad++; $display("FAIL mid_done got=%0d want=0", done_cnt); end
    for (int i = 2; i < 6; i++) begin
      buf_addr = 8'(i);
      tick();
      total++;
      if (buf_dout !== exp_buf[i]) begin
        bad++; $display("FAIL mid_buf[%0d] got=%0h want=%0h", i, buf_dout, exp_buf[i]);
      end
    end
    clr_mon();
    start(1'b1, 1'b0, 8'd3, 9'd8);
    wait_idle("replay");
    total += 3;
    if (wr_cnt != 8) begin bad++; $display("FAIL replay_wr got=%0d want=8", wr_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL replay_done got=%0d want=1", done_cnt); end
    if (mon_bad != 0) begin bad++; $display("FAIL replay_stream errors=%0d want=0", mon_bad); end
  endtask

  task automatic test_full();
    logic [8:0] lens [0:1];
    lens = '{9'd256, 9'd300};
    for (int i = 0; i < 256; i++) host_write(8'(i), 8'(i) ^ 8'h5A);
    for (int k = 0; k < 2; k++) begin
      clr_mon();
      start(1'b1, 1'b0, 8'd2, lens[k]);
      wait_idle("full");
      total += 4;
      if (wr_cnt != 256) begin bad++; $display("FAIL full%0d_wr got=%0d want=256", k, wr_cnt); end
      if (last_addr !== 25'd255) begin bad++; $display("FAIL full%0d_last got=%0h want=ff", k, last_addr); end
      if (done_cnt != 1) begin bad++; $display("FAIL full%0d_done got=%0d want=1", k, done_cnt); end
      if (mon_bad != 0) begin bad++; $display("FAIL full%0d_stream errors=%0d want=0", k, mon_bad); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_buf[i] = 8'h00;
    test_reset();
    test_download();
    test_upload();
    test_len0();
    test_both_starts();
    test_reset_mid();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
